// File: rtl/mem_ls_unit.sv
// -----------------------------------------------------------------------------
// mem_ls_unit -- memory-access stage between EXE and WB.
//
// Drives a synchronous data RAM directly. It handles byte/half/word loads
// (signed and unsigned) and byte/half/word stores. The data RAM read latency
// is LOAD_LAT cycles. A store is issued exactly once, even while the stage
// is stalled.
//
// Optional feature, selected by the macro MEM_MISALIGN_EXC_EN:
//   defined   : a misaligned half/word access raises addr_exc. The store
//               write is suppressed, a load completes at once, and
//               mem_result carries the faulting address.
//   undefined : addr_exc is tied low and the low address bits are ignored
//               (the access is aligned down).
//
// Parameters:
//   LOAD_LAT  data RAM read latency, address to dm_rdata valid (1..7)
//   ADDR_W    width of dm_addr (3..32)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   MEM_valid       stage holds a valid instruction
//   MEM_allow_in    stage accepts a new instruction next edge (retires current)
//   inst_load       instruction is a load
//   inst_store      instruction is a store (wins if both are set)
//   ls_size         00 byte, 01 half, 10/11 word
//   ls_unsigned     zero-extend load result
//   exe_result      effective address / ALU result
//   store_data      store source value
//   dm_rdata        data RAM read data
//   dm_addr         RAM address, aligned down to the access size
//   dm_wen          byte write enables
//   dm_wdata        lane-replicated store data
//   MEM_over        stage finished its work this cycle
//   mem_result      load result, or exe_result for everything else
//   addr_exc        misaligned access
// -----------------------------------------------------------------------------
module mem_ls_unit #(
  parameter int LOAD_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_valid,
  input  logic              MEM_allow_in,
  input  logic              inst_load,
  input  logic              inst_store,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [31:0]       exe_result,
  input  logic [31:0]       store_data,
  input  logic [31:0]       dm_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wen,
  output logic [31:0]       dm_wdata,
  output logic              MEM_over,
  output logic [31:0]       mem_result,
  output logic              addr_exc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    DONE   = 2'd2,
    STORED = 2'd3
  } state_t;

  localparam logic [2:0] LAT_C = 3'(LOAD_LAT);

  state_t      state, state_next;
  logic [2:0]  lat_cnt, lat_cnt_next;
  logic [31:0] rdata_r;
  logic        capture;

  // Access decode. A store wins over a load if both are flagged.
  logic       is_store, is_load, is_byte, is_half;
  logic [1:0] low_bits;
  logic       exc;

  assign is_store = inst_store;
  assign is_load  = inst_load & ~inst_store;
  assign is_byte  = (ls_size == 2'b00);
  assign is_half  = (ls_size == 2'b01);

  // Low address bits after aligning down to the access size.
  assign low_bits = is_byte ? exe_result[1:0] :
                    is_half ? {exe_result[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_EXC_EN
  logic misaligned;
  assign misaligned = (is_half & exe_result[0]) |
                      (~is_byte & ~is_half & (exe_result[1:0] != 2'b00));
  assign exc = MEM_valid & (inst_load | inst_store) & misaligned;
`else
  assign exc = 1'b0;
`endif

  assign dm_addr  = {exe_result[ADDR_W-1:2], low_bits};
  assign addr_exc = exc & ~rst;

  // ---------------------------------------------------------------------------
  // State register, latency counter and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
      rdata_r <= 32'd0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      if (capture) begin
        rdata_r <= dm_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    capture      = 1'b0;
    unique case (state)
      IDLE: begin
        if (MEM_valid) begin
          if (is_store) begin
            // The write happens in this cycle. STORED only holds MEM_over
            // while the stage is stalled, so the write is never repeated.
            // If the stage retires at once, stay in IDLE for the next one.
            if (!exc && !MEM_allow_in) begin
              state_next = STORED;
            end
          end else if (is_load && !exc) begin
            state_next   = WAIT;
            lat_cnt_next = 3'd1;
          end
        end
      end
      WAIT: begin
        if (!MEM_valid) begin
          // Flush: drop the read in flight.
          state_next   = IDLE;
          lat_cnt_next = 3'd0;
        end else if (lat_cnt == LAT_C) begin
          capture      = 1'b1;
          state_next   = DONE;
          lat_cnt_next = 3'd0;
        end else begin
          lat_cnt_next = lat_cnt + 3'd1;
        end
      end
      DONE, STORED: begin
        if (MEM_allow_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  assign load_byte = rdata_r[{exe_result[1:0], 3'b000} +: 8];
  assign load_half = exe_result[1] ? rdata_r[31:16] : rdata_r[15:0];

  always_comb begin
    load_value = rdata_r;
    if (is_byte) begin
      load_value = {{24{~ls_unsigned & load_byte[7]}}, load_byte};
    end else if (is_half) begin
      load_value = {{16{~ls_unsigned & load_half[15]}}, load_half};
    end
  end

  always_comb begin
    MEM_over   = 1'b0;
    dm_wen     = 4'b0000;
    dm_wdata   = store_data;
    mem_result = (is_load && !exc) ? load_value : exe_result;

    if (is_byte) begin
      dm_wdata = {4{store_data[7:0]}};
    end else if (is_half) begin
      dm_wdata = {2{store_data[15:0]}};
    end

    unique case (state)
      IDLE: begin
        // Only an aligned load needs further cycles.
        MEM_over = MEM_valid & ~(is_load & ~exc);
        if (MEM_valid && is_store && !exc) begin
          if (is_byte) begin
            dm_wen = 4'b0001 << low_bits;
          end else if (is_half) begin
            dm_wen = 4'b0011 << low_bits;
          end else begin
            dm_wen = 4'b1111;
          end
        end
      end
      WAIT:         MEM_over = 1'b0;
      DONE, STORED: MEM_over = 1'b1;
      default:      MEM_over = 1'b0;
    endcase

    // Reset cuts any write in flight short without waiting for a clock.
    if (rst) begin
      MEM_over = 1'b0;
      dm_wen   = 4'b0000;
    end
  end

endmodule
